// File: rtl/ram_dp_clr.sv
`default_nettype none
// ============================================================================
// Module   : ram_dp_clr
// Purpose  : Simple dual-port RAM (one write port, one read port) with a
//            pipelined read carrying a valid strobe, selectable read/write
//            collision behaviour and a sequential bulk-clear engine that
//            walks every address writing CLR_VAL.
// Ports    : clk      - clock, rising edge
//            rstn     - asynchronous active-low reset
//            wr       - write enable        wrAdr  - write address
//            dataIn   - write data
//            rd       - read request        rdAdr  - read address
//            dataOut  - read data (holds last result)
//            rdValid  - one-cycle strobe marking dataOut valid
//            clr      - start-clear pulse   busy   - clear in progress
// Revision : 1.0 - initial release
// ============================================================================
module ram_dp_clr #(
  parameter int               WIDTH       = 8,
  parameter int               DEPTH       = 16,
  parameter int               ADR_W       = $clog2(DEPTH),
  parameter int               RD_LAT      = 1,
  parameter int               WRITE_FIRST = 1,
  parameter logic [WIDTH-1:0] CLR_VAL     = '0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             wr,
  input  logic [ADR_W-1:0] wrAdr,
  input  logic [WIDTH-1:0] dataIn,
  input  logic             rd,
  input  logic [ADR_W-1:0] rdAdr,
  output logic [WIDTH-1:0] dataOut,
  output logic             rdValid,
  input  logic             clr,
  output logic             busy
);

  // One extra bit so DEPTH itself is representable for range checks
  localparam logic [ADR_W:0]   DEPTH_EXT = (ADR_W + 1)'(DEPTH);
  localparam logic [ADR_W-1:0] LAST_ADR  = ADR_W'(DEPTH - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t           state, next_state;
  logic [ADR_W-1:0] cnt, next_cnt;

  logic [WIDTH-1:0] mem [DEPTH];

  logic             idle;
  logic             wr_ok;
  logic             rd_in_range;
  logic             launch;
  logic             mem_we;
  logic [ADR_W-1:0] mem_wa;
  logic [WIDTH-1:0] mem_wd;
  logic [WIDTH-1:0] rd_word;

  // First read stage: always present
  logic             s1_vld;
  logic [WIDTH-1:0] s1_data;

  // --------------------------------------------------------------------------
  // Clear FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
    end
  end

  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    case (state)
      IDLE: begin
        if (clr) begin
          next_state = CLEAR;
          next_cnt   = '0;
        end
      end
      CLEAR: begin
        if (cnt == LAST_ADR) begin
          next_state = IDLE;
          next_cnt   = '0;
        end else begin
          next_cnt = cnt + ADR_W'(1);
        end
      end
      default: begin
        next_state = IDLE;
        next_cnt   = '0;
      end
    endcase
  end

  assign idle = (state == IDLE);
  assign busy = (state == CLEAR);

  // --------------------------------------------------------------------------
  // Write port: the clear engine owns the port while busy. Writes are gated
  // by rstn so an aborted clear leaves memory untouched while reset is held.
  // --------------------------------------------------------------------------
  assign wr_ok       = idle && wr && ({1'b0, wrAdr} < DEPTH_EXT);
  assign rd_in_range = ({1'b0, rdAdr} < DEPTH_EXT);
  assign launch      = idle && rd;

  assign mem_we = rstn && (busy || wr_ok);
  assign mem_wa = busy ? cnt : wrAdr;
  assign mem_wd = busy ? CLR_VAL : dataIn;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_wa] <= mem_wd;
    end
  end

  // --------------------------------------------------------------------------
  // Read port: out-of-range reads return zero; a same-address write in the
  // same cycle is forwarded only in write-first mode, otherwise the array's
  // pre-write contents are returned.
  // --------------------------------------------------------------------------
  always_comb begin
    rd_word = '0;
    if (rd_in_range) begin
      if ((WRITE_FIRST != 0) && wr_ok && (wrAdr == rdAdr)) begin
        rd_word = dataIn;
      end else begin
        rd_word = mem[rdAdr];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_vld  <= 1'b0;
      s1_data <= '0;
    end else begin
      s1_vld <= launch;
      if (launch) begin
        s1_data <= rd_word;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Optional second read stage. Data registers only load on a valid result,
  // so dataOut holds its last value between strobes.
  // --------------------------------------------------------------------------
  generate
    if (RD_LAT >= 2) begin : g_lat2
      logic             s2_vld;
      logic [WIDTH-1:0] s2_data;

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          s2_vld  <= 1'b0;
          s2_data <= '0;
        end else begin
          s2_vld <= s1_vld;
          if (s1_vld) begin
            s2_data <= s1_data;
          end
        end
      end

      assign dataOut = s2_data;
      assign rdValid = s2_vld;
    end else begin : g_lat1
      assign dataOut = s1_data;
      assign rdValid = s1_vld;
    end
  endgenerate

endmodule
`default_nettype wire
